// File: rtl/alu_pkg.sv
// Shared opcode encoding and helpers for the sequential ALU and its
// iterative multiply/divide engine.
package alu_pkg;

    localparam int OP_W = 3;

    typedef logic [OP_W-1:0] op_t;

    localparam op_t OP_ADD  = 3'd0;
    localparam op_t OP_SUB  = 3'd1;
    localparam op_t OP_AND  = 3'd2;
    localparam op_t OP_OR   = 3'd3;
    localparam op_t OP_XOR  = 3'd4;
    localparam op_t OP_SLT  = 3'd5;
    localparam op_t OP_MUL  = 3'd6;
    localparam op_t OP_DIVU = 3'd7;

    function automatic logic is_multicycle(input op_t op);
        return (op == OP_MUL) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
// DONE flags the final step; LO/HI/DIVZERO then show that step's result.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             OP_DIV,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] LO,
    output logic [WIDTH-1:0] HI,
    output logic             DIVZERO
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] b_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             div_q;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_fits;

    // HI holds the partial product (MUL) or partial remainder (DIVU);
    // LO holds the multiplier being shifted out or the quotient shifted in.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_fits  = (div_shift >= {1'b0, b_q});
        if (div_q) begin
            hi_d = div_fits ? (div_shift[WIDTH-1:0] - b_q) : div_shift[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], div_fits};
        end else begin
            hi_d = mul_sum[WIDTH:1];
            lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            hi_q   <= '0;
            lo_q   <= '0;
            b_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            div_q  <= 1'b0;
        end else if (START) begin
            hi_q   <= '0;
            lo_q   <= A;
            b_q    <= B;
            cnt_q  <= CNT_W'(WIDTH);
            busy_q <= 1'b1;
            div_q  <= OP_DIV;
        end else if (busy_q) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
                busy_q <= 1'b0;
            end
        end
    end

    // With B == 0 every trial subtract fits, so the quotient saturates to all
    // ones and the remainder ends up equal to A without special casing.
    assign BUSY    = busy_q;
    assign DONE    = busy_q && (cnt_q == CNT_W'(1));
    assign LO      = lo_d;
    assign HI      = hi_d;
    assign DIVZERO = div_q && (b_q == '0);

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshake: single-cycle logic/arith ops,
// iterative MUL/DIVU via alu_muldiv, registered result and flags.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             READY,
    input  logic [OP_W-1:0]  OP,
    input  logic [WIDTH-1:0] INPUTA,
    input  logic [WIDTH-1:0] INPUTB,
    output logic [WIDTH-1:0] OUT,
    output logic [WIDTH-1:0] HI,
    output logic             OUT_VALID,
    output logic             ZERO,
    output logic             EQUAL,
    output logic             CARRY,
    output logic             OVERFLOW,
    output logic             DIVZERO
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]       state_q, state_d;
    logic             ready_q, ready_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             valid_q, valid_d;
    logic             zero_q, zero_d;
    logic             equal_q, equal_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             divz_q, divz_d;
    logic             eq_pend_q, eq_pend_d;

    logic             accept;
    logic             start;
    logic [WIDTH:0]   add_w;
    logic [WIDTH:0]   sub_w;
    logic             a_msb, b_msb;
    logic             md_busy, md_done, md_divz;
    logic [WIDTH-1:0] md_lo, md_hi;

    alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .CLK     (CLK),
        .RST     (RST),
        .START   (start),
        .OP_DIV  (OP == OP_DIVU),
        .A       (INPUTA),
        .B       (INPUTB),
        .BUSY    (md_busy),
        .DONE    (md_done),
        .LO      (md_lo),
        .HI      (md_hi),
        .DIVZERO (md_divz)
    );

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        accept = IN_VALID && ready_q;
        start  = accept && is_multicycle(OP);
        add_w  = {1'b0, INPUTA} + {1'b0, INPUTB};
        sub_w  = {1'b0, INPUTA} - {1'b0, INPUTB};
        a_msb  = INPUTA[WIDTH-1];
        b_msb  = INPUTB[WIDTH-1];

        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_BUSY;
            default: if (md_done || !md_busy) state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_IDLE);

        out_d     = out_q;
        hi_d      = hi_q;
        zero_d    = zero_q;
        equal_d   = equal_q;
        carry_d   = carry_q;
        ovf_d     = ovf_q;
        divz_d    = divz_q;
        valid_d   = 1'b0;
        eq_pend_d = start ? (INPUTA == INPUTB) : eq_pend_q;

        if (accept && !is_multicycle(OP)) begin
            hi_d    = '0;
            carry_d = 1'b0;
            ovf_d   = 1'b0;
            divz_d  = 1'b0;
            valid_d = 1'b1;
            equal_d = (INPUTA == INPUTB);
            case (OP)
                OP_ADD: begin
                    out_d   = add_w[WIDTH-1:0];
                    carry_d = add_w[WIDTH];
                    ovf_d   = (a_msb == b_msb) && (add_w[WIDTH-1] != a_msb);
                end
                OP_SUB: begin
                    out_d   = sub_w[WIDTH-1:0];
                    carry_d = sub_w[WIDTH];
                    ovf_d   = (a_msb != b_msb) && (sub_w[WIDTH-1] != a_msb);
                end
                OP_AND:  out_d = INPUTA & INPUTB;
                OP_OR:   out_d = INPUTA | INPUTB;
                OP_XOR:  out_d = INPUTA ^ INPUTB;
                OP_SLT:  out_d = {{(WIDTH-1){1'b0}}, $signed(INPUTA) < $signed(INPUTB)};
                default: out_d = '0;
            endcase
            zero_d = (out_d == '0);
        end else if (md_done) begin
            out_d   = md_lo;
            hi_d    = md_hi;
            zero_d  = (md_lo == '0);
            equal_d = eq_pend_q;
            carry_d = 1'b0;
            ovf_d   = 1'b0;
            divz_d  = md_divz;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            ready_q   <= 1'b0;
            out_q     <= '0;
            hi_q      <= '0;
            valid_q   <= 1'b0;
            zero_q    <= 1'b0;
            equal_q   <= 1'b0;
            carry_q   <= 1'b0;
            ovf_q     <= 1'b0;
            divz_q    <= 1'b0;
            eq_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            out_q     <= out_d;
            hi_q      <= hi_d;
            valid_q   <= valid_d;
            zero_q    <= zero_d;
            equal_q   <= equal_d;
            carry_q   <= carry_d;
            ovf_q     <= ovf_d;
            divz_q    <= divz_d;
            eq_pend_q <= eq_pend_d;
        end
    end

    assign READY     = ready_q;
    assign OUT       = out_q;
    assign HI        = hi_q;
    assign OUT_VALID = valid_q;
    assign ZERO      = zero_q;
    assign EQUAL     = equal_q;
    assign CARRY     = carry_q;
    assign OVERFLOW  = ovf_q;
    assign DIVZERO   = divz_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed corner cases followed by random
// traffic, compared every cycle against an arithmetic reference model.
module tb_alu_seq;

    localparam int W = 16;

    logic         CLK = 1'b0;
    logic         RST;
    logic         IN_VALID;
    logic         READY;
    logic [2:0]   OP;
    logic [W-1:0] INPUTA, INPUTB;
    logic [W-1:0] OUT, HI;
    logic         OUT_VALID, ZERO, EQUAL, CARRY, OVERFLOW, DIVZERO;

    always #5 CLK = ~CLK;

    alu_seq #(.WIDTH(W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .READY     (READY),
        .OP        (OP),
        .INPUTA    (INPUTA),
        .INPUTB    (INPUTB),
        .OUT       (OUT),
        .HI        (HI),
        .OUT_VALID (OUT_VALID),
        .ZERO      (ZERO),
        .EQUAL     (EQUAL),
        .CARRY     (CARRY),
        .OVERFLOW  (OVERFLOW),
        .DIVZERO   (DIVZERO)
    );

    typedef struct {
        logic [W-1:0] out;
        logic [W-1:0] hi;
        logic         zero, equal, carry, ovf, divz;
    } res_t;

    res_t exp_r, pend_r;
    logic exp_valid = 1'b0;
    logic exp_ready = 1'b0;
    bit   busy_m    = 1'b0;
    int   due_m     = 0;
    int   cyc       = 0;
    int   n_checks  = 0;
    int   n_fail    = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic res_t zero_res();
        res_t r;
        r.out = '0; r.hi = '0;
        r.zero = 1'b0; r.equal = 1'b0; r.carry = 1'b0; r.ovf = 1'b0; r.divz = 1'b0;
        return r;
    endfunction

    // Reference results from plain integer arithmetic.
    function automatic res_t ref_calc(input int op, input int a, input int b);
        res_t   r;
        longint s, sa, sb, ss;
        r  = zero_res();
        sa = (a >= 32768) ? a - 65536 : a;
        sb = (b >= 32768) ? b - 65536 : b;
        case (op)
            0: begin
                s = a + b; r.out = W'(s); r.carry = (s > 65535);
                ss = sa + sb; r.ovf = (ss > 32767) || (ss < -32768);
            end
            1: begin
                s = a - b; r.out = W'(s); r.carry = (a < b);
                ss = sa - sb; r.ovf = (ss > 32767) || (ss < -32768);
            end
            2: r.out = W'(a & b);
            3: r.out = W'(a | b);
            4: r.out = W'(a ^ b);
            5: r.out = (sa < sb) ? 16'd1 : 16'd0;
            6: begin
                s = longint'(a) * longint'(b);
                r.out = W'(s % 65536); r.hi = W'(s / 65536);
            end
            default: begin
                if (b == 0) begin
                    r.out = 16'hFFFF; r.hi = W'(a); r.divz = 1'b1;
                end else begin
                    r.out = W'(a / b); r.hi = W'(a % b);
                end
            end
        endcase
        r.zero  = (r.out == 0);
        r.equal = (a == b);
        return r;
    endfunction

    // Advances the model by one clock edge using the inputs the DUT just sampled.
    task automatic model_step();
        if (RST) begin
            exp_r     = zero_res();
            exp_valid = 1'b0;
            exp_ready = 1'b0;
            busy_m    = 1'b0;
        end else begin
            exp_valid = 1'b0;
            if (busy_m) begin
                if (cyc == due_m) begin
                    exp_r     = pend_r;
                    exp_valid = 1'b1;
                    busy_m    = 1'b0;
                end
            end else if (exp_ready && IN_VALID) begin
                if (OP < 3'd6) begin
                    exp_r     = ref_calc(int'(OP), int'(INPUTA), int'(INPUTB));
                    exp_valid = 1'b1;
                end else begin
                    pend_r = ref_calc(int'(OP), int'(INPUTA), int'(INPUTB));
                    busy_m = 1'b1;
                    due_m  = cyc + W;
                end
            end
            exp_ready = !busy_m;
        end
    endtask

    task automatic compare();
        check("READY",     W'(READY),     W'(exp_ready));
        check("OUT_VALID", W'(OUT_VALID), W'(exp_valid));
        check("OUT",       OUT,           exp_r.out);
        check("HI",        HI,            exp_r.hi);
        check("ZERO",      W'(ZERO),      W'(exp_r.zero));
        check("EQUAL",     W'(EQUAL),     W'(exp_r.equal));
        check("CARRY",     W'(CARRY),     W'(exp_r.carry));
        check("OVERFLOW",  W'(OVERFLOW),  W'(exp_r.ovf));
        check("DIVZERO",   W'(DIVZERO),   W'(exp_r.divz));
    endtask

    task automatic tick();
        @(posedge CLK);
        cyc++;
        model_step();
        #1;
        compare();
    endtask

    task automatic apply(input logic rst, input logic iv, input logic [2:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        RST = rst; IN_VALID = iv; OP = op; INPUTA = a; INPUTB = b;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(1'b0, 1'b0, 3'd0, '0, '0);
    endtask

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] corners [5];
        corners = '{16'h0000, 16'h0001, 16'hFFFF, 16'h8000, 16'h7FFF};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
        return W'($urandom);
    endfunction

    initial begin
        RST = 1'b1; IN_VALID = 1'b0; OP = '0; INPUTA = '0; INPUTB = '0;
        for (int i = 0; i < 3; i++) apply(1'b1, 1'b0, 3'd0, '0, '0);
        idle(1);

        // Single-cycle corners issued back to back.
        apply(1'b0, 1'b1, 3'd0, 16'h0004, 16'h0004);
        apply(1'b0, 1'b1, 3'd1, 16'h0004, 16'h0004);
        apply(1'b0, 1'b1, 3'd0, 16'h7FFF, 16'h0001);
        apply(1'b0, 1'b1, 3'd1, 16'h0003, 16'h0004);
        apply(1'b0, 1'b1, 3'd5, 16'hFFFF, 16'h0001);
        idle(2);

        // MUL with IN_VALID held high; the ADD lands in the completion cycle.
        apply(1'b0, 1'b1, 3'd6, 16'h1234, 16'h0010);
        for (int i = 0; i < W + 1; i++) apply(1'b0, 1'b1, 3'd0, 16'h0011, 16'h0022);
        idle(2);

        apply(1'b0, 1'b1, 3'd7, 16'd100, 16'd7);
        idle(W + 1);
        apply(1'b0, 1'b1, 3'd7, 16'h0005, 16'h0000);
        idle(W + 1);

        apply(1'b0, 1'b1, 3'd0, 16'h1111, 16'h2222);
        apply(1'b0, 1'b1, 3'd4, 16'hF0F0, 16'h0FF0);
        apply(1'b0, 1'b1, 3'd3, 16'h1200, 16'h0034);
        idle(2);

        // Reset in the middle of a MUL aborts it.
        apply(1'b0, 1'b1, 3'd6, 16'hABCD, 16'h1234);
        idle(7);
        apply(1'b1, 1'b0, 3'd0, '0, '0);
        apply(1'b1, 1'b0, 3'd0, '0, '0);
        idle(1);
        apply(1'b0, 1'b1, 3'd0, 16'h0100, 16'h0023);
        idle(2);

        for (int i = 0; i < 1500; i++) begin
            apply(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) < 7),
                  3'($urandom_range(0, 7)), pick_operand(), pick_operand());
        end
        idle(W + 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
